// File: rtl/de2_70_cpu_oci_monitor.sv
// Debug monitor memory stage: JTAG-driven read/write FSM plus a CPU slave port
// sharing one single-port debug RAM, with JTAG always taking priority.
module de2_70_cpu_oci_monitor #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAP, WR} stateType;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  stateType          state_q, state_d;
  logic [ADDR_W-1:0] monAddr_q, monAddr_d;
  logic [31:0]       monDReg_q, monDReg_d;
  logic [31:0]       wrData_q, wrData_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              cpuAck_q, cpuAck_d;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ramRdata_q;
  logic [ADDR_W-1:0] ramAddr;
  logic [31:0]       ramWdata;
  logic              ramWe;
  logic              takeAny;
  logic              cpuReq;
  logic              unusedJdoBits;

  assign takeAny       = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign cpuReq        = cpu_read | cpu_write;
  assign unusedJdoBits = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    state_d   = state_q;
    monAddr_d = monAddr_q;
    monDReg_d = monDReg_q;
    wrData_d  = wrData_q;
    ready_d   = ready_q;
    error_d   = error_q;
    cpuAck_d  = 1'b0;
    ramAddr   = monAddr_q;
    ramWdata  = wrData_q;
    ramWe     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          monAddr_d = jdo[26 +: ADDR_W];
          if (jdo[24]) error_d = 1'b0;
          if (jdo[25]) begin
            ready_d = 1'b0;
            state_d = RD_ISSUE;
          end
        end else if (take_no_action_ocimem_a) begin
          monAddr_d = monAddr_q + ADDR_ONE;
          ready_d   = 1'b0;
          state_d   = RD_ISSUE;
        end else if (take_action_ocimem_b) begin
          if (debugack) begin
            wrData_d = jdo[34:3];
            ready_d  = 1'b0;
            state_d  = WR;
          end else begin
            error_d = 1'b1;
          end
        end else if (cpuReq && !cpuAck_q) begin
          // CPU only gets the RAM on cycles where JTAG leaves it untouched
          ramAddr  = cpu_address;
          ramWdata = cpu_writedata;
          ramWe    = cpu_write;
          cpuAck_d = 1'b1;
        end
      end
      RD_ISSUE: begin
        if (takeAny) error_d = 1'b1;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        if (takeAny) error_d = 1'b1;
        monDReg_d = ramRdata_q;
        ready_d   = 1'b1;
        state_d   = IDLE;
      end
      WR: begin
        if (takeAny) error_d = 1'b1;
        ramWe     = 1'b1;
        monAddr_d = monAddr_q + ADDR_ONE;
        ready_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      monAddr_q <= '0;
      monDReg_q <= '0;
      wrData_q  <= '0;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
      cpuAck_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      monAddr_q <= monAddr_d;
      monDReg_q <= monDReg_d;
      wrData_q  <= wrData_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      cpuAck_q  <= cpuAck_d;
    end
  end

  // RAM contents survive reset, but a write pending at the reset edge is dropped
  always_ff @(posedge clk) begin
    if (ramWe && !reset) mem[ramAddr] <= ramWdata;
    ramRdata_q <= mem[ramAddr];
  end

  assign cpu_readdata    = ramRdata_q;
  assign cpu_waitrequest = cpuReq & ~cpuAck_q;
  assign MonDReg         = monDReg_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;

  // Simultaneous read and write performs the write and returns stale data
  noReadWriteTogether: assert property (@(posedge clk) disable iff (reset) !(cpu_read && cpu_write));

endmodule

// File: tb/tb_de2_70_cpu_oci_monitor.sv
// Self-checking bench for de2_70_cpu_oci_monitor: a reference memory model feeds
// expected read data into queues that are drained as the DUT completes reads.
module tb_de2_70_cpu_oci_monitor;

  localparam int K_A     = 0;
  localparam int K_NOACT = 1;
  localparam int K_B     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic        debugack;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [256];
  logic [7:0]  modelAddr = '0;
  logic [31:0] jtagQ [$];
  logic [31:0] cpuQ [$];

  de2_70_cpu_oci_monitor #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .debugack                (debugack),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] jdoA(input logic [7:0] addr, input logic rd, input logic clr);
    return {4'b0, addr, rd, clr, 24'b0};
  endfunction

  function automatic logic [37:0] jdoB(input logic [31:0] data);
    return {3'b0, data, 3'b0};
  endfunction

  // Drives a one-cycle take pulse; returns one time unit after the edge that sampled it
  task automatic applyStimulus(input int kind, input logic [37:0] word);
    jdo                     = word;
    take_action_ocimem_a    = (kind == K_A);
    take_no_action_ocimem_a = (kind == K_NOACT);
    take_action_ocimem_b    = (kind == K_B);
    @(posedge clk); #1;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic jtagSetAddr(input logic [7:0] addr, input logic clr);
    applyStimulus(K_A, jdoA(addr, 1'b0, clr));
    modelAddr = addr;
  endtask

  task automatic jtagWrite(input logic [31:0] data);
    applyStimulus(K_B, jdoB(data));
    checkOutput("wrReadyLow", 32'(monitor_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("wrReadyHigh", 32'(monitor_ready), 32'd1);
    model[modelAddr] = data;
    modelAddr        = modelAddr + 8'd1;
  endtask

  task automatic jtagRead(input logic cont, input logic [7:0] addr);
    int n;
    logic [31:0] exp;
    if (cont) modelAddr = modelAddr + 8'd1;
    else      modelAddr = addr;
    jtagQ.push_back(model[modelAddr]);
    applyStimulus(cont ? K_NOACT : K_A, jdoA(addr, 1'b1, 1'b0));
    checkOutput("rdReadyLow", 32'(monitor_ready), 32'd0);
    n = 0;
    while (!monitor_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rdLatency", 32'(n), 32'd2);
    if (jtagQ.size() == 0) begin
      checkOutput("rdQueueEmpty", 32'd0, 32'd1);
    end else begin
      exp = jtagQ.pop_front();
      checkOutput("rdData", MonDReg, exp);
    end
  endtask

  task automatic cpuAccess(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           output int edges);
    logic [31:0] exp;
    cpu_address   = addr;
    cpu_writedata = data;
    cpu_write     = wr;
    cpu_read      = !wr;
    if (wr) model[addr] = data;
    else    cpuQ.push_back(model[addr]);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (cpu_waitrequest && edges < 10);
    checkOutput("cpuWaitDone", 32'(cpu_waitrequest), 32'd0);
    if (!wr) begin
      if (cpuQ.size() == 0) begin
        checkOutput("cpuQueueEmpty", 32'd0, 32'd1);
      end else begin
        exp = cpuQ.pop_front();
        checkOutput("cpuRdData", cpu_readdata, exp);
      end
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int edges;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    debugack = 1'b1;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rstReady", 32'(monitor_ready), 32'd1);
    checkOutput("rstError", 32'(monitor_error), 32'd0);
    checkOutput("rstMonDReg", MonDReg, 32'd0);
    checkOutput("rstWaitReq", 32'(cpu_waitrequest), 32'd0);

    jtagSetAddr(8'h10, 1'b0);
    checkOutput("setAddrReady", 32'(monitor_ready), 32'd1);
    jtagWrite(32'hDEADBEEF);
    jtagWrite(32'hCAFEF00D);
    jtagRead(1'b0, 8'h10);
    jtagRead(1'b1, 8'h00);

    // Address wrap on write, then continuation read past the wrap
    jtagSetAddr(8'h00, 1'b0);
    jtagWrite(32'h01010101);
    jtagWrite(32'h02020202);
    jtagSetAddr(8'hFF, 1'b0);
    jtagWrite(32'hFFFF0000);
    jtagRead(1'b1, 8'h00);
    jtagRead(1'b0, 8'hFF);

    debugack = 1'b0;
    applyStimulus(K_B, jdoB(32'hBAD0BAD0));
    checkOutput("noAckError", 32'(monitor_error), 32'd1);
    checkOutput("noAckReady", 32'(monitor_ready), 32'd1);
    debugack = 1'b1;
    jtagRead(1'b0, 8'h10);
    checkOutput("errorSticky", 32'(monitor_error), 32'd1);
    jtagSetAddr(8'h10, 1'b1);
    checkOutput("errorCleared", 32'(monitor_error), 32'd0);

    // Pulse during RD_ISSUE must be dropped without disturbing the read
    fork
      jtagRead(1'b0, 8'h10);
      begin
        @(posedge clk); #2;
        applyStimulus(K_NOACT, jdoA(8'h00, 1'b1, 1'b0));
      end
    join
    checkOutput("dropError", 32'(monitor_error), 32'd1);
    jtagRead(1'b1, 8'h00);
    jtagSetAddr(8'h00, 1'b1);
    checkOutput("dropErrorCleared", 32'(monitor_error), 32'd0);

    // CPU write collides with a JTAG read pulse
    fork
      jtagRead(1'b0, 8'h10);
      begin
        cpuAccess(1'b1, 8'h20, 32'h12345678, edges);
        checkOutput("cpuStallEdges", 32'(edges), 32'd4);
      end
    join
    cpuAccess(1'b0, 8'h20, 32'h0, edges);
    checkOutput("cpuRdEdges", 32'(edges), 32'd1);
    cpuAccess(1'b1, 8'h21, 32'hA5A55A5A, edges);
    checkOutput("cpuWrEdges", 32'(edges), 32'd1);
    jtagRead(1'b0, 8'h20);
    jtagRead(1'b1, 8'h00);

    // Reset while in WR: the write is abandoned
    jtagSetAddr(8'h30, 1'b0);
    jtagWrite(32'h11111111);
    jtagSetAddr(8'h30, 1'b0);
    applyStimulus(K_B, jdoB(32'h22222222));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midRstReady", 32'(monitor_ready), 32'd1);
    checkOutput("midRstMonDReg", MonDReg, 32'd0);
    checkOutput("midRstError", 32'(monitor_error), 32'd0);
    jtagRead(1'b0, 8'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
